// File: rtl/rf_bank_port_ctrl_if.sv
// Bus bundle between a register-file bank port controller and its
// environment: write request stream, read request stream (with tag),
// response stream, and the single bank port (we/addr/din/dout).
//
// slave  : the controller's view (accepts requests, drives the bank port).
// master : the environment's view (issues requests, models the bank).
interface rf_bank_port_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [TAG_WIDTH-1:0]  rd_tag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr, rd_tag,
    input  rsp_ready, bram_dout,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data, rsp_tag,
    output bram_we, bram_addr, bram_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr, rd_tag,
    output rsp_ready, bram_dout,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    input  bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/rf_bank_port_ctrl.sv
// Client-side controller for one single-port, output-registered,
// write-first register-file bank.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - rf_bank_port_ctrl_if.slave:
//            wr_* write request stream, rd_* read request stream with tag,
//            rsp_* response stream (first-word-fall-through FIFO head),
//            bram_* single bank port; bram_dout valid one cycle after addr.
//
// One request is granted per cycle. Contention alternates starting with
// write after reset. Reads only win a grant when a response slot is
// guaranteed (queued + in-flight < RSP_DEPTH), so the FIFO cannot overflow.
module rf_bank_port_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input logic                clk,
  input logic                rst_n,
  rf_bank_port_ctrl_if.slave bus
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int ENT_W = DATA_WIDTH + TAG_WIDTH;

  logic [ENT_W-1:0]      mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  write_elig, read_elig;
  logic                  grant_wr, grant_rd;
  logic                  push, pop, rsp_valid;
  logic [ENT_W-1:0]      head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (int'(p) == RSP_DEPTH - 1) n = '0;
    else                          n = p + 1'b1;
    return n;
  endfunction

  always_comb begin
    write_elig = bus.wr_valid;
    // No credit for a pop happening this same cycle.
    read_elig  = bus.rd_valid && ((int'(count_q) + int'(inflight_q)) < RSP_DEPTH);
    // Gating with rst_n keeps readies and the bank port quiet while reset is low.
    grant_wr   = rst_n && write_elig && (!read_elig || !last_wr_q);
    grant_rd   = rst_n && read_elig  && (!write_elig || last_wr_q);

    rsp_valid  = (count_q != '0);
    push       = inflight_q;
    pop        = rsp_valid && bus.rsp_ready;

    if (grant_wr)      addr_d = bus.wr_addr;
    else if (grant_rd) addr_d = bus.rd_addr;
    else               addr_d = addr_q;

    if (grant_wr)      last_wr_d = 1'b1;
    else if (grant_rd) last_wr_d = 1'b0;
    else               last_wr_d = last_wr_q;

    // A read accepted this cycle keeps the stage occupied while the
    // previous one (if any) drains into the FIFO.
    inflight_d = grant_rd;
    tag_d      = grant_rd ? bus.rd_tag : tag_q;

    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      last_wr_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.bram_dout, tag_q};
  end

  assign head          = mem_q[rd_ptr_q];

  assign bus.wr_ready  = grant_wr;
  assign bus.rd_ready  = grant_rd;
  assign bus.bram_we   = grant_wr;
  assign bus.bram_addr = addr_d;
  assign bus.bram_din  = grant_wr ? bus.wr_data : '0;
  assign bus.rsp_valid = rsp_valid;
  // Zero when empty so the response bus is clean out of reset.
  assign bus.rsp_data  = rsp_valid ? head[ENT_W-1:TAG_WIDTH] : '0;
  assign bus.rsp_tag   = rsp_valid ? head[TAG_WIDTH-1:0]     : '0;

endmodule

// File: tb/tb_rf_bank_port_ctrl.sv
module tb_rf_bank_port_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_bank_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  rf_bank_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  // Bank model: single port, write-first, registered output, word i = i at power-up.
  logic [DW-1:0] bank [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) bank[i] = DW'(i);
    bus.bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bus.bram_we === 1'b1) begin
      bank[bus.bram_addr] <= bus.bram_din;
      bus.bram_dout       <= bus.bram_din;
    end else begin
      bus.bram_dout       <= bank[bus.bram_addr];
    end
  end

  // Reference model: memory image, queue of expected responses in
  // acceptance order, and the alternation bit.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } rsp_t;
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [1 << AW];
  logic          ref_last_wr;
  logic [AW-1:0] ref_last_addr;
  logic          m_re, m_ew, m_er;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
    ref_last_wr   = 1'b0;
    ref_last_addr = '0;
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      ref_last_wr   = 1'b0;
      ref_last_addr = '0;
    end else begin
      m_re = bus.rd_valid && (exp_q.size() < DEPTH);
      m_ew = bus.wr_valid && (!m_re || !ref_last_wr);
      m_er = m_re && (!bus.wr_valid || ref_last_wr);
      total++;
      if (bus.wr_ready !== m_ew || bus.rd_ready !== m_er || bus.bram_we !== m_ew) begin
        bad++;
        $display("FAIL grant: wr_ready=%b rd_ready=%b bram_we=%b want wr=%b rd=%b",
                 bus.wr_ready, bus.rd_ready, bus.bram_we, m_ew, m_er);
      end
      m_addr = m_ew ? bus.wr_addr : (m_er ? bus.rd_addr : ref_last_addr);
      m_din  = m_ew ? bus.wr_data : '0;
      total++;
      if (bus.bram_addr !== m_addr || bus.bram_din !== m_din) begin
        bad++;
        $display("FAIL port: addr=%0d din=%h want addr=%0d din=%h",
                 bus.bram_addr, bus.bram_din, m_addr, m_din);
      end
      if (bus.bram_we === 1'b1) we_cnt++;
      if (bus.rsp_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: data=%h tag=%0d want no response",
                   bus.rsp_data, bus.rsp_tag);
        end else if ({bus.rsp_data, bus.rsp_tag} !== exp_q[0]) begin
          bad++;
          $display("FAIL rsp_data: data=%h tag=%0d want data=%h tag=%0d",
                   bus.rsp_data, bus.rsp_tag, exp_q[0].d, exp_q[0].t);
        end
        if (bus.rsp_ready === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (m_ew) begin
        ref_mem[bus.wr_addr] = bus.wr_data;
        ref_last_wr   = 1'b1;
        ref_last_addr = bus.wr_addr;
      end else if (m_er) begin
        exp_q.push_back({ref_mem[bus.rd_addr], bus.rd_tag});
        ref_last_wr   = 1'b0;
        ref_last_addr = bus.rd_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.count_q > DEPTH) begin
      bad++;
      $display("FAIL fifo_count: count=%0d limit=%0d", dut.count_q, DEPTH);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_tag  = '0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain;
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    total++;
    if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d rsp_valid=%b want 0 and 0", exp_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 32'hFFFF_0000;
    bus.rd_valid = 1'b1; bus.rd_addr = 3'd3; bus.rd_tag  = 4'd9;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.bram_we,
           bus.bram_addr, bus.bram_din, bus.rsp_data, bus.rsp_tag} !== '0) begin
        bad++;
        $display("FAIL reset_hold: wr_rdy=%b rd_rdy=%b rsp_v=%b we=%b addr=%0d din=%h data=%h tag=%0d want all 0",
                 bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.bram_we,
                 bus.bram_addr, bus.bram_din, bus.rsp_data, bus.rsp_tag);
      end
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.bram_we, bus.bram_addr, bus.rsp_data} !== '0) begin
      bad++;
      $display("FAIL reset_release: rsp_v=%b we=%b addr=%0d data=%h want 0",
               bus.rsp_valid, bus.bram_we, bus.bram_addr, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_powerup_reads;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.rd_valid = (c < 8);
      bus.rd_addr  = AW'(c);
      bus.rd_tag   = TW'(c);
      @(negedge clk);
      if (c < 8) begin
        total++;
        if (bus.rd_ready !== 1'b1) begin
          bad++;
          $display("FAIL pu_rd_ready c=%0d: got %b want 1", c, bus.rd_ready);
        end
      end
      if (c >= 2 && c < 10) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== DW'(c - 2) || bus.rsp_tag !== TW'(c - 2)) begin
          bad++;
          $display("FAIL pu_rsp c=%0d: valid=%b data=%h tag=%0d want 1 %h %0d",
                   c, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, c - 2, c - 2);
        end
      end
      tick();
    end
    idle();
    drain();
  endtask

  task automatic test_write_read;
    int w0;
    bus.rsp_ready = 1'b1;
    w0 = we_cnt;
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (bus.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_accept: wr_ready=%b want 1", bus.wr_ready);
    end
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (we_cnt - w0 != 1) begin
      bad++;
      $display("FAIL we_pulse: cycles=%0d want 1", we_cnt - w0);
    end
    bus.rd_valid = 1'b1; bus.rd_addr = 3'd5; bus.rd_tag = 4'd3;
    @(negedge clk);
    total++;
    if (bus.rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_accept: rd_ready=%b want 1", bus.rd_ready);
    end
    tick();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_early: rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEAD_BEEF || bus.rsp_tag !== 4'd3) begin
      bad++;
      $display("FAIL wr_rd_rsp: valid=%b data=%h tag=%0d want 1 deadbeef 3",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
    end
    tick();
    drain();
  endtask

  task automatic test_alternate;
    int nw, nr;
    nw = 0; nr = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = $urandom;
      bus.rd_valid = 1'b1; bus.rd_addr = AW'($urandom); bus.rd_tag  = TW'($urandom);
      @(negedge clk);
      total++;
      if (bus.wr_ready !== (c % 2 == 0) || bus.rd_ready !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL alt_grant c=%0d: wr=%b rd=%b want wr=%b rd=%b",
                 c, bus.wr_ready, bus.rd_ready, (c % 2 == 0), (c % 2 == 1));
      end
      if (bus.wr_ready === 1'b1) nw++;
      if (bus.rd_ready === 1'b1) nr++;
      tick();
    end
    idle();
    total++;
    if (nw != 4 || nr != 4) begin
      bad++;
      $display("FAIL alt_counts: writes=%0d reads=%0d want 4 4", nw, nr);
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic resumed;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(c); bus.rd_tag = TW'(c);
      bus.wr_valid = (c >= 4); bus.wr_addr = 3'd7; bus.wr_data = $urandom;
      @(negedge clk);
      total++;
      if (bus.rd_ready !== (c < 4) || bus.wr_ready !== (c >= 4)) begin
        bad++;
        $display("FAIL bp_grant c=%0d: rd=%b wr=%b want rd=%b wr=%b",
                 c, bus.rd_ready, bus.wr_ready, (c < 4), (c >= 4));
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.rd_addr = 3'd1; bus.rd_tag = 4'hA;
    resumed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== TW'(k)) begin
        bad++;
        $display("FAIL bp_rsp k=%0d: valid=%b tag=%0d want 1 %0d", k, bus.rsp_valid, bus.rsp_tag, k);
      end
      if (bus.rd_ready === 1'b1) resumed = 1'b1;
      tick();
    end
    total++;
    if (resumed !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume: reads resumed=%b want 1", resumed);
    end
    drain();
  endtask

  task automatic test_same_cycle;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 32'h55;
    bus.rd_valid = 1'b1; bus.rd_addr = 3'd2; bus.rd_tag  = 4'd5;
    @(negedge clk);
    total++;
    if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin
      bad++;
      $display("FAIL same_first: wr=%b rd=%b want 1 0", bus.wr_ready, bus.rd_ready);
    end
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL same_second: rd=%b want 1", bus.rd_ready);
    end
    tick();
    bus.rd_valid = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h55 || bus.rsp_tag !== 4'd5) begin
      bad++;
      $display("FAIL same_rsp: valid=%b data=%h tag=%0d want 1 55 5",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_midop;
    logic [DW-1:0] want4;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(c); bus.rd_tag = TW'(c + 1);
      @(negedge clk);
      total++;
      if (bus.rd_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_fill c=%0d: rd_ready=%b want 1", c, bus.rd_ready);
      end
      tick();
    end
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 32'hA5A5_1234;
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.bram_we,
         bus.bram_addr, bus.bram_din, bus.rsp_data, bus.rsp_tag} !== '0) begin
      bad++;
      $display("FAIL mid_reset: wr_rdy=%b rd_rdy=%b rsp_v=%b we=%b addr=%0d din=%h data=%h tag=%0d want all 0",
               bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.bram_we,
               bus.bram_addr, bus.bram_din, bus.rsp_data, bus.rsp_tag);
    end
    @(posedge clk); #1;
    idle();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_stale c=%0d: rsp_valid=%b want 0", c, bus.rsp_valid);
      end
      tick();
    end
    want4 = ref_mem[4];
    bus.rd_valid = 1'b1; bus.rd_addr = 3'd4; bus.rd_tag = 4'hC;
    @(negedge clk);
    total++;
    if (bus.rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_newrd: rd_ready=%b want 1", bus.rd_ready);
    end
    tick();
    bus.rd_valid = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'hC || bus.rsp_data !== want4) begin
      bad++;
      $display("FAIL mid_rsp: valid=%b data=%h tag=%0d want 1 %h 12",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag, want4);
    end
    tick();
    drain();
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      bus.wr_valid  = ($urandom_range(0, 99) < 45);
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = $urandom;
      bus.rd_valid  = ($urandom_range(0, 99) < 60);
      bus.rd_addr   = AW'($urandom);
      bus.rd_tag    = TW'($urandom);
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_powerup_reads();
    test_write_read();
    test_alternate();
    test_backpressure();
    test_same_cycle();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_bank_port_ctrl.md
Name: rf_bank_port_ctrl

Overview:
- Client-side controller for one single-port, output-registered, write-first register-file BRAM bank.
- Accepts independent write and read request streams (valid/ready), arbitrates them onto the bank's single port (we/addr/din), and captures bank dout one cycle after each read.
- Returns read data plus tag through a backpressurable response FIFO.
- Sits between the operand-collector / writeback logic and each RF bank.

Parameters:
- ADDR_WIDTH, 3, bank address width (bank depth 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, word width.
- TAG_WIDTH, 4, requester tag carried with each read.
- RSP_DEPTH, 4, response FIFO depth; must be >= 3 for sustained one-read-per-cycle throughput.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_tag  in  TAG_WIDTH  read tag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_tag  out  TAG_WIDTH  tag of returned read.
- bram_we  out  1  bank write enable.
- bram_addr  out  ADDR_WIDTH  bank address.
- bram_din  out  DATA_WIDTH  bank write data.
- bram_dout  in  DATA_WIDTH  bank registered read data, valid the cycle after the address is presented.

Behaviour:
- Reset (rst_n low, async): FIFO emptied, inflight cleared, last_grant=READ. wr_ready, rd_ready, rsp_valid, bram_we = 0. bram_addr, bram_din, rsp_data, rsp_tag = 0. All of these are held while rst_n is low.
- Eligibility:
  - write_elig = wr_valid.
  - read_elig = rd_valid && (fifo_count + inflight) < RSP_DEPTH. No same-cycle pop credit.
- Arbitration, one grant per cycle:
  - Only one eligible: grant it.
  - Both eligible: grant the opposite of last_grant.
  - last_grant updates on every grant. After reset, the first contention goes to write.
- wr_ready / rd_ready are combinational and equal the grant. A handshake occurs when valid && ready.
- Port drive (combinational from grant):
  - Write grant: bram_we=1, bram_addr=wr_addr, bram_din=wr_data.
  - Read grant: bram_we=0, bram_addr=rd_addr, bram_din=0.
  - No grant: bram_we=0, bram_addr holds its last value (registered copy), bram_din=0.
- Read pipeline:
  - Read accepted at edge E0: inflight=1 and tag latched at E0.
  - At E1, bram_dout and the latched tag are pushed into the FIFO and inflight is cleared, unless another read was accepted at E1, in which case inflight stays 1.
  - rsp_valid is asserted in the cycle after E1. Minimum latency is 2 cycles from acceptance to rsp_valid.
- Response FIFO: first-word-fall-through. rsp_data/rsp_tag show the head. Pop on rsp_valid && rsp_ready. Push and pop in the same cycle are legal; count is unchanged.
- Ordering: responses return strictly in read-acceptance order. Bank accesses execute in grant order, so a read granted after a write to the same address returns the new data.
- Overflow is impossible by construction. The bench asserts fifo_count <= RSP_DEPTH.
- Reads of unwritten locations return the bank's power-up contents (word i = i).
- Reset mid-operation: in-flight and queued responses are discarded; no response appears after release. A write granted in the reset cycle is not issued.
- Throughput: with RSP_DEPTH >= 3 and rsp_ready held high, one read per cycle is sustained indefinitely.

Test Plan:
- Reset, write addr 5 data 0xDEADBEEF, then read addr 5 tag 3 -> bram_we high exactly 1 cycle; rsp_valid 2 cycles after read accept with rsp_data=0xDEADBEEF, rsp_tag=3.
- Power-up reads of addr 0..7 back-to-back, tags 0..7, rsp_ready=1 -> rd_ready never drops; rsp_data/rsp_tag = 0..7 on consecutive cycles, in order.
- wr_valid and rd_valid both held high for 8 cycles, buffer not full -> grants W,R,W,R,... starting with W; exactly 4 writes and 4 reads issued.
- rsp_ready=0, stream reads -> exactly 4 accepted, then rd_ready=0 while writes still granted; raise rsp_ready -> 4 responses in order, then reads resume.
- Write addr 2 = 0x55 and read addr 2 presented together after reset -> write first; read returns 0x55.
- rst_n pulsed low with 1 read in flight and 2 queued -> all outputs 0 immediately; no rsp_valid after release until a new read is accepted.
